sw_debounce: RTL and testbench

//  Cleans the raw active-low push-switch input sw_in_n before it reaches the LED toggle logic.
//  - Synchronises sw_in_n into clk.
//  - Samples it on a divided-clock tick, which is a clk-domain enable (no derived clock).
//  - Filters bounce with a stable-count state machine.
//  - Emits a debounced level plus one-clk press, release and long-press pulses.
//  The downstream toggle stage consumes press_pulse as a clk enable and never edge-clocks on the switch.

---
 rtl/sw_debounce_pkg.sv | 15 +
 rtl/tick_gen.sv | 26 ++
 rtl/sw_debounce.sv | 167 ++++++++++++++++
 tb/tb_sw_debounce.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer and its prescaler.
package sw_debounce_pkg;

  // Debounce FSM states; the encodings are shared with other slow-sampled inputs.
  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } db_state_t;

  // Default prescaler width: 33 MHz / 2^15 gives a sample tick of about 1 kHz.
  localparam int DEFAULT_DIV_BITS = 15;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: free-running counter that produces a one-clk enable each time it
// is all-ones, i.e. once every 2^DIV_BITS clk. No derived clock is created.
module tick_gen
  import sw_debounce_pkg::*;
#(
  parameter int DIV_BITS = DEFAULT_DIV_BITS
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_BITS-1:0] r_div;

  // Up-counter that wraps from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign tick = &r_div;

endmodule

// File: rtl/sw_debounce.sv
// Debouncer for an active-low push switch: two-flop synchroniser, tick-sampled
// stable-count FSM, registered level plus press/release/long-press pulses.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int DIV_BITS     = DEFAULT_DIV_BITS,
  parameter int STABLE_TICKS = 8,
  parameter int HOLD_TICKS   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in_n,
  output logic sw_pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  logic              w_tick;
  logic              r_sync1;
  logic              r_sync2;
  db_state_t         r_state;
  db_state_t         w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_next;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              w_press_next;
  logic              w_release_next;
  logic              w_long_next;
  logic              w_level_next;
  logic              r_sw_pressed;
  logic              r_press;
  logic              r_release;
  logic              r_long;

  tick_gen #(
    .DIV_BITS(DIV_BITS)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Two-flop synchroniser; idles high (released) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= sw_in_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_hold_inc   = r_hold + 1'b1;
  assign w_level_next = (w_state_next == ST_PRESSED) || (w_state_next == ST_RELEASE_CHK);

  // Next-state, counter and pulse decisions; everything holds except on a tick.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_hold_next    = r_hold;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_long_next    = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_RELEASED: begin
          if (!r_sync2) begin
            if (STABLE_TICKS == 1) begin
              w_state_next = ST_PRESSED;
              w_cnt_next   = '0;
              w_hold_next  = '0;
              w_press_next = 1'b1;
            end else begin
              w_state_next = ST_PRESS_CHK;
              w_cnt_next   = CNT_W'(1);
            end
          end
        end
        ST_PRESS_CHK: begin
          if (r_sync2) begin
            w_state_next = ST_RELEASED;
            w_cnt_next   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_next = ST_PRESSED;
            w_cnt_next   = '0;
            w_hold_next  = '0;
            w_press_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (r_sync2) begin
            if (STABLE_TICKS == 1) begin
              w_state_next   = ST_RELEASED;
              w_cnt_next     = '0;
              w_release_next = 1'b1;
            end else begin
              w_state_next = ST_RELEASE_CHK;
              w_cnt_next   = CNT_W'(1);
            end
          end
        end
        ST_RELEASE_CHK: begin
          if (!r_sync2) begin
            w_state_next = ST_PRESSED;
            w_cnt_next   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_next   = ST_RELEASED;
            w_cnt_next     = '0;
            w_release_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = ST_RELEASED;
          w_cnt_next   = '0;
        end
      endcase
      // Hold time accrues while the switch stays accepted as pressed. The tick
      // that completes a release does not count, so long-press can never
      // coincide with release_pulse.
      if (((r_state == ST_PRESSED) || (r_state == ST_RELEASE_CHK)) &&
          (w_state_next != ST_RELEASED) && (r_hold != HOLD_MAX)) begin
        w_hold_next = w_hold_inc;
        w_long_next = (w_hold_inc == HOLD_MAX);
      end
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RELEASED;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_sw_pressed <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_long       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_hold       <= w_hold_next;
      r_sw_pressed <= w_level_next;
      r_press      <= w_press_next;
      r_release    <= w_release_next;
      r_long       <= w_long_next;
    end
  end

  assign sw_pressed       = r_sw_pressed;
  assign press_pulse      = r_press;
  assign release_pulse    = r_release;
  assign long_press_pulse = r_long;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (DIV_BITS=2, STABLE_TICKS=3, HOLD_TICKS=5).
// A cycle-level reference model checks every output on every clk; scenario
// counters check the event counts and spacings the switch behaviour demands.
module tb_sw_debounce;

  localparam int DIV_BITS = 2;
  localparam int TICK_PER = 1 << DIV_BITS;
  localparam int ST       = 3;
  localparam int HOLD     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_in_n = 1'b1;
  logic sw_pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic m_d_old = 1'b1;   // value seen by the FSM at the next edge (2 clk late)
  logic m_d_new = 1'b1;
  int   m_n     = 0;      // posedges since reset released
  int   m_idx   = 0;      // index of the most recent checked edge
  int   m_run   = 0;      // consecutive tick samples disagreeing with the level
  int   m_held  = 0;      // ticks held since press acceptance
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_rel   = 1'b0;
  logic m_long  = 1'b0;

  // Scenario counters
  int n_press = 0;
  int n_rel   = 0;
  int n_long  = 0;
  int press_at = -1;
  int long_at  = -1;

  sw_debounce #(
    .DIV_BITS     (DIV_BITS),
    .STABLE_TICKS (ST),
    .HOLD_TICKS   (HOLD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sw_in_n          (sw_in_n),
    .sw_pressed       (sw_pressed),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: tick every TICK_PER clk after reset; a change is
  // accepted after ST consecutive tick samples of the opposite level; long
  // press when HOLD further ticks have passed while still pressed.
  task automatic model_edge(input logic rst_v, input logic sw_v);
    logic smp;
    logic was;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (rst_v) begin
      m_d_old = 1'b1;
      m_d_new = 1'b1;
      m_n     = 0;
      m_idx   = 0;
      m_run   = 0;
      m_held  = 0;
      m_level = 1'b0;
      return;
    end
    smp     = m_d_old;
    m_d_old = m_d_new;
    m_d_new = sw_v;
    if ((m_n % TICK_PER) == TICK_PER - 1) begin
      was = m_level;
      if (!smp != m_level) begin
        m_run++;
        if (m_run == ST) begin
          m_level = !smp;
          m_run   = 0;
          if (m_level) begin
            m_press = 1'b1;
            m_held  = 0;
          end else begin
            m_rel = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      if (was && m_level && m_held < HOLD) begin
        m_held++;
        if (m_held == HOLD) m_long = 1'b1;
      end
    end
    m_idx = m_n;
    m_n++;
  endtask

  task automatic clear_counts();
    n_press  = 0;
    n_rel    = 0;
    n_long   = 0;
    press_at = -1;
    long_at  = -1;
  endtask

  // One clk: drive on the falling edge, advance model at the rising edge,
  // compare 1 time unit later.
  task automatic step(input logic rst_v, input logic sw_v);
    @(negedge clk);
    rst     = rst_v;
    sw_in_n = sw_v;
    @(posedge clk);
    model_edge(rst_v, sw_v);
    #1;
    check_eq("sw_pressed", int'(sw_pressed), int'(m_level));
    check_eq("press_pulse", int'(press_pulse), int'(m_press));
    check_eq("release_pulse", int'(release_pulse), int'(m_rel));
    check_eq("long_press_pulse", int'(long_press_pulse), int'(m_long));
    check_eq("pulse_exclusive",
             int'((int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse)) <= 1), 1);
    if (press_pulse === 1'b1) begin
      n_press++;
      press_at = m_idx;
      $display("press   pulse at edge %0d (t=%0t)", m_idx, $time);
    end
    if (release_pulse === 1'b1) begin
      n_rel++;
      $display("release pulse at edge %0d (t=%0t)", m_idx, $time);
    end
    if (long_press_pulse === 1'b1) begin
      n_long++;
      long_at = m_idx;
      $display("long    pulse at edge %0d (t=%0t)", m_idx, $time);
    end
  endtask

  task automatic drive(input logic sw_v, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, sw_v);
  endtask

  initial begin
    // 1. Reset held with the switch pressed; press accepted 3 ticks later
    //    (first tick at edge 3, third at edge 11).
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    drive(1'b0, 16);
    check_eq("s1_press_count", n_press, 1);
    check_eq("s1_press_edge", press_at, 11);

    // 2/4. Clean press held 20 ticks: one press, one long press 5 ticks later.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
    drive(1'b1, 10);
    clear_counts();
    drive(1'b0, 20 * TICK_PER + 12);
    check_eq("s2_press_count", n_press, 1);
    check_eq("s4_long_count", n_long, 1);
    check_eq("s4_long_delay", long_at - press_at, HOLD * TICK_PER);
    check_eq("s2_level", int'(sw_pressed), 1);

    // 5. One-tick high glitch is rejected, then a real release is accepted.
    clear_counts();
    drive(1'b1, TICK_PER);
    drive(1'b0, 20);
    check_eq("s5_glitch_release", n_rel, 0);
    check_eq("s5_glitch_level", int'(sw_pressed), 1);
    drive(1'b1, 20);
    check_eq("s5_release_count", n_rel, 1);
    check_eq("s5_release_level", int'(sw_pressed), 0);
    check_eq("s5_no_repress", n_press + n_long, 0);

    // 3. Bounce per tick: L L H L L L -> exactly one press after the last low.
    clear_counts();
    drive(1'b0, 2 * TICK_PER);
    drive(1'b1, TICK_PER);
    drive(1'b0, 3 * TICK_PER + 8);
    check_eq("s3_press_count", n_press, 1);
    check_eq("s3_release_count", n_rel, 0);
    drive(1'b1, 20);

    // 6. Reset while in PRESS_CHK with cnt=2 (after the 2nd low tick, edge 7).
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    clear_counts();
    drive(1'b0, 9);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    check_eq("s6_no_pulse_before", n_press + n_rel + n_long, 0);
    drive(1'b0, 10);
    check_eq("s6_not_yet", n_press, 0);
    drive(1'b0, 4);
    check_eq("s6_fresh_press", n_press, 1);
    check_eq("s6_fresh_edge", press_at, 11);

    // Randomized bouncing segments with occasional resets.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(20, 60)));
      end else begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
